// File: rtl/jtcps1_vram_pkg.sv
// Shared client identifiers, arbiter state encoding and grant helper for the CPS1 VRAM read arbiter.
package jtcps1_vram_pkg;

    localparam int NCL = 3;

    localparam logic [1:0] CL_SCR = 2'd0;
    localparam logic [1:0] CL_OBJ = 2'd1;
    localparam logic [1:0] CL_PAL = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    // Round-robin successor in the order scroll -> obj -> pal -> scroll.
    function automatic logic [1:0] next_cl(input logic [1:0] c);
        logic [1:0] n;
        case (c)
            CL_SCR:  n = CL_OBJ;
            CL_OBJ:  n = CL_PAL;
            default: n = CL_SCR;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jtcps1_vram_slot.sv
// One client's cached VRAM word: last filled address, data and valid, plus the ok/pending decode.
module jtcps1_vram_slot
    import jtcps1_vram_pkg::*;
#(
    parameter int AW = 23
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr,
    input  logic          cs,
    input  logic          busy,
    input  logic          fill,
    input  logic [AW-1:0] fill_addr,
    input  logic [15:0]   fill_data,
    output logic [15:0]   data,
    output logic          ok,
    output logic          pending
);

    logic [AW-1:0] last_addr_q, last_addr_d;
    logic [15:0]   data_q, data_d;
    logic          valid_q, valid_d;

    // Next-state of the cache entry: a fill only validates if the client still holds cs.
    always_comb begin
        last_addr_d = last_addr_q;
        data_d      = data_q;
        valid_d     = valid_q & cs;
        if (fill) begin
            last_addr_d = fill_addr;
            data_d      = fill_data;
            valid_d     = cs;
        end else begin
            valid_d     = valid_q & cs;
        end
    end

    // Cache entry registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_addr_q <= {AW{1'b0}};
            data_q      <= 16'h0000;
            valid_q     <= 1'b0;
        end else begin
            last_addr_q <= last_addr_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
        end
    end

    assign ok      = valid_q & cs & (addr == last_addr_q);
    assign pending = cs & ~ok & ~busy;
    assign data    = data_q;

endmodule

// File: rtl/jtcps1_vram_arb.sv
// CPS1 VRAM read arbiter: scroll/object/palette clients share one SDRAM read port.
// Define VRAM_ARB_RR_EN for round-robin grant; otherwise fixed priority obj > scroll > pal.
module jtcps1_vram_arb
    import jtcps1_vram_pkg::*;
#(
    parameter int            AW      = 23,
    parameter int            PALW    = 18,
    parameter logic [AW-1:0] PAL_OFF = {AW{1'b0}}
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [23:1]     vram1_addr,
    input  logic            vram1_cs,
    output logic [15:0]     vram1_data,
    output logic            vram1_ok,
    input  logic [23:1]     vobj_addr,
    input  logic            vobj_cs,
    output logic [15:0]     vobj_data,
    output logic            vobj_ok,
    input  logic [PALW-1:0] vpal_addr,
    input  logic            vpal_cs,
    output logic [15:0]     vpal_data,
    output logic            vpal_ok,
    output logic [AW:1]     sdram_addr,
    output logic            sdram_req,
    input  logic            sdram_ack,
    input  logic            sdram_rdy,
    input  logic [15:0]     sdram_din
);

    state_t          state_q, state_d;
    logic [1:0]      cl_q, cl_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            req_q, req_d;

    logic [AW-1:0]   cl_addr_s [NCL];
    logic [15:0]     data_s    [NCL];
    logic [NCL-1:0]  cs_s, ok_s, pend_s, busy_s, fill_s;
    logic            fill_any_s;
    logic            grant_vld_s;
    logic [1:0]      grant_cl_s;

    // Palette sits at PAL_OFF in SDRAM; the sum wraps at 2^AW.
    assign cl_addr_s[CL_SCR] = AW'(vram1_addr);
    assign cl_addr_s[CL_OBJ] = AW'(vobj_addr);
    assign cl_addr_s[CL_PAL] = PAL_OFF + AW'(vpal_addr);
    assign cs_s              = {vpal_cs, vobj_cs, vram1_cs};

    // A simultaneous ack+rdy in WAIT is a complete fill.
    assign fill_any_s = ((state_q == ST_DATA) & sdram_rdy) |
                        ((state_q == ST_WAIT) & sdram_ack & sdram_rdy);

    // Per-slot service and fill strobes.
    always_comb begin
        busy_s = {NCL{1'b0}};
        fill_s = {NCL{1'b0}};
        for (int i = 0; i < NCL; i++) begin
            busy_s[i] = (state_q != ST_IDLE) & (cl_q == 2'(i));
            fill_s[i] = fill_any_s & (cl_q == 2'(i));
        end
    end

    for (genvar g = 0; g < NCL; g++) begin : g_slot
        jtcps1_vram_slot #(.AW(AW)) u_slot (
            .clk       (clk),
            .rst       (rst),
            .addr      (cl_addr_s[g]),
            .cs        (cs_s[g]),
            .busy      (busy_s[g]),
            .fill      (fill_s[g]),
            .fill_addr (addr_q),
            .fill_data (sdram_din),
            .data      (data_s[g]),
            .ok        (ok_s[g]),
            .pending   (pend_s[g])
        );
    end

`ifdef VRAM_ARB_RR_EN
    logic [1:0] last_q;
    logic [1:0] c0_s, c1_s, c2_s;

    assign c0_s = next_cl(last_q);
    assign c1_s = next_cl(c0_s);
    assign c2_s = next_cl(c1_s);

    // Round-robin search starting after the last granted client.
    always_comb begin
        grant_vld_s = 1'b1;
        grant_cl_s  = c0_s;
        if (pend_s[c0_s]) begin
            grant_cl_s = c0_s;
        end else if (pend_s[c1_s]) begin
            grant_cl_s = c1_s;
        end else if (pend_s[c2_s]) begin
            grant_cl_s = c2_s;
        end else begin
            grant_vld_s = 1'b0;
        end
    end

    // Last-granted pointer; resets to pal so the first search begins at scroll.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= CL_PAL;
        end else if ((state_q == ST_IDLE) && grant_vld_s) begin
            last_q <= grant_cl_s;
        end else begin
            last_q <= last_q;
        end
    end
`else
    // Fixed priority grant: obj > scroll > pal.
    always_comb begin
        grant_vld_s = 1'b1;
        grant_cl_s  = CL_OBJ;
        if (pend_s[CL_OBJ]) begin
            grant_cl_s = CL_OBJ;
        end else if (pend_s[CL_SCR]) begin
            grant_cl_s = CL_SCR;
        end else if (pend_s[CL_PAL]) begin
            grant_cl_s = CL_PAL;
        end else begin
            grant_vld_s = 1'b0;
        end
    end
`endif

    // Arbiter next state; an issued SDRAM read always runs to completion.
    always_comb begin
        state_d = state_q;
        cl_d    = cl_q;
        addr_d  = addr_q;
        req_d   = req_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_vld_s) begin
                    state_d = ST_WAIT;
                    cl_d    = grant_cl_s;
                    addr_d  = cl_addr_s[grant_cl_s];
                    req_d   = 1'b1;
                end else begin
                    req_d   = 1'b0;
                end
            end
            ST_WAIT: begin
                if (sdram_ack) begin
                    req_d   = 1'b0;
                    state_d = sdram_rdy ? ST_IDLE : ST_DATA;
                end else begin
                    req_d   = 1'b1;
                end
            end
            ST_DATA: begin
                if (sdram_rdy) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DATA;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // Arbiter state and registered SDRAM request outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cl_q    <= CL_SCR;
            addr_q  <= {AW{1'b0}};
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cl_q    <= cl_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
        end
    end

    assign sdram_addr = addr_q;
    assign sdram_req  = req_q;
    assign vram1_data = data_s[CL_SCR];
    assign vobj_data  = data_s[CL_OBJ];
    assign vpal_data  = data_s[CL_PAL];
    assign vram1_ok   = ok_s[CL_SCR];
    assign vobj_ok    = ok_s[CL_OBJ];
    assign vpal_ok    = ok_s[CL_PAL];

endmodule

// File: tb/tb_jtcps1_vram_arb.sv
// Self-checking bench for jtcps1_vram_arb: directed vector table, corner sequences, random traffic.
module tb_jtcps1_vram_arb;

    localparam logic [22:0] PAL_OFF = 23'h020000;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:1] vram1_addr, vobj_addr;
    logic [17:0] vpal_addr;
    logic        vram1_cs, vobj_cs, vpal_cs;
    logic [15:0] vram1_data, vobj_data, vpal_data;
    logic        vram1_ok, vobj_ok, vpal_ok;
    logic [23:1] sdram_addr;
    logic        sdram_req, sdram_ack, sdram_rdy;
    logic [15:0] sdram_din;

    int checks   = 0;
    int failures = 0;

    int          ack_dly   = 0;
    int          rdy_dly   = 1;
    bit          rand_resp = 1'b0;
    bit          force_en  = 1'b0;
    logic [15:0] force_data = 16'h0000;

    logic [22:0] cur_addr [3];
    logic        cur_cs   [3];
    logic [2:0]  ok_all;
    logic [15:0] data_all [3];

    jtcps1_vram_arb #(.AW(23), .PALW(18), .PAL_OFF(PAL_OFF)) dut (
        .clk(clk), .rst(rst),
        .vram1_addr(vram1_addr), .vram1_cs(vram1_cs), .vram1_data(vram1_data), .vram1_ok(vram1_ok),
        .vobj_addr(vobj_addr), .vobj_cs(vobj_cs), .vobj_data(vobj_data), .vobj_ok(vobj_ok),
        .vpal_addr(vpal_addr), .vpal_cs(vpal_cs), .vpal_data(vpal_data), .vpal_ok(vpal_ok),
        .sdram_addr(sdram_addr), .sdram_req(sdram_req), .sdram_ack(sdram_ack),
        .sdram_rdy(sdram_rdy), .sdram_din(sdram_din)
    );

    always #5 clk = ~clk;

    assign ok_all      = {vpal_ok, vobj_ok, vram1_ok};
    assign data_all[0] = vram1_data;
    assign data_all[1] = vobj_data;
    assign data_all[2] = vpal_data;

    typedef struct {
        int          cl;
        logic [22:0] addr;
        int          ack_d;
        int          rdy_d;
        logic [15:0] data;
        logic [22:0] exp_sa;
        int          exp_lat;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [15:0] mem_word(input logic [22:0] a);
        return a[15:0] ^ {a[22:16], 9'h15B};
    endfunction

    function automatic logic [22:0] eff_addr(input int cl, input logic [22:0] a);
        logic [22:0] r;
        if (cl == 2) r = PAL_OFF + {5'd0, a[17:0]};
        else         r = a;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply();
        vram1_addr = cur_addr[0];
        vobj_addr  = cur_addr[1];
        vpal_addr  = cur_addr[2][17:0];
        vram1_cs   = cur_cs[0];
        vobj_cs    = cur_cs[1];
        vpal_cs    = cur_cs[2];
    endtask

    task automatic drive_client(input int cl, input logic cs, input logic [22:0] a);
        cur_cs[cl]   = cs;
        cur_addr[cl] = a;
        apply();
    endtask

    // SDRAM controller model: level request, ack after ack_dly cycles, data rdy_dly cycles after ack.
    initial begin : sdram_model
        int          a, r;
        logic [15:0] d;
        sdram_ack = 1'b0;
        sdram_rdy = 1'b0;
        sdram_din = 16'h0000;
        forever begin
            @(posedge clk); #1;
            if (sdram_req) begin
                a = rand_resp ? int'($urandom_range(0, 2)) : ack_dly;
                r = rand_resp ? int'($urandom_range(0, 2)) : rdy_dly;
                d = force_en ? force_data : mem_word(sdram_addr);
                repeat (a) begin @(posedge clk); #1; end
                sdram_ack = 1'b1;
                if (r == 0) begin sdram_rdy = 1'b1; sdram_din = d; end
                @(posedge clk); #1;
                sdram_ack = 1'b0;
                sdram_rdy = 1'b0;
                if (r > 0) begin
                    repeat (r - 1) begin @(posedge clk); #1; end
                    sdram_rdy = 1'b1;
                    sdram_din = d;
                    @(posedge clk); #1;
                    sdram_rdy = 1'b0;
                end
            end
        end
    end

    task automatic run_single(input vec_t v);
        int lat;
        bit seen;
        ack_dly = v.ack_d; rdy_dly = v.rdy_d;
        force_en = 1'b1;   force_data = v.data;
        @(negedge clk);
        drive_client(v.cl, 1'b1, v.addr);
        lat = -1; seen = 1'b0;
        for (int c = 1; c <= 20 && lat < 0; c++) begin
            @(negedge clk);
            if (sdram_req && !seen) begin
                seen = 1'b1;
                check("req_addr", 32'(sdram_addr), 32'(v.exp_sa));
            end
            if (ok_all[v.cl]) lat = c;
        end
        check("req_seen", 32'(seen), 32'd1);
        check("latency", lat, v.exp_lat);
        check("data", 32'(data_all[v.cl]), 32'(v.data));
        repeat (3) @(negedge clk);
        check("ok_held", 32'(ok_all[v.cl]), 32'd1);
        drive_client(v.cl, 1'b0, v.addr);
        #1 check("ok_cs_low", 32'(ok_all[v.cl]), 32'd0);
        @(negedge clk);
        drive_client(v.cl, 1'b1, v.addr);
        #1 check("valid_cleared", 32'(ok_all[v.cl]), 32'd0);
        #1 drive_client(v.cl, 1'b0, v.addr);
        repeat (3) @(negedge clk);
        force_en = 1'b0;
    endtask

    task automatic arb_round(input logic [22:0] base);
        int          order [3];
        logic [22:0] exp_sa [3];
        int          n;
        logic        prev;
`ifdef VRAM_ARB_RR_EN
        order = '{0, 1, 2};
`else
        order = '{1, 0, 2};
`endif
        ack_dly = 0; rdy_dly = 1; force_en = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) drive_client(k, 1'b1, base + 23'(k + 1));
        for (int k = 0; k < 3; k++) exp_sa[k] = eff_addr(order[k], base + 23'(order[k] + 1));
        n = 0; prev = sdram_req;
        for (int c = 0; c < 40 && ok_all != 3'b111; c++) begin
            @(negedge clk);
            if (sdram_req && !prev) begin
                if (n < 3) check("arb_order", 32'(sdram_addr), 32'(exp_sa[n]));
                n++;
            end
            prev = sdram_req;
        end
        check("arb_all_ok", 32'(ok_all), 32'h7);
        check("arb_req_count", n, 3);
        for (int k = 0; k < 3; k++)
            check("arb_data", 32'(data_all[k]), 32'(mem_word(eff_addr(k, base + 23'(k + 1)))));
        for (int k = 0; k < 3; k++) drive_client(k, 1'b0, cur_addr[k]);
        repeat (3) @(negedge clk);
    endtask

    initial begin : main
        int          n, wait_cnt [3];
        bit          bad_ok, hit;
        logic        prev;
        logic [22:0] a2;
        logic [22:0] na;

        vecs[0] = '{cl:0, addr:23'h001000, ack_d:0, rdy_d:1, data:16'hBEEF, exp_sa:23'h001000, exp_lat:3};
        vecs[1] = '{cl:1, addr:23'h000200, ack_d:1, rdy_d:1, data:16'h5555, exp_sa:23'h000200, exp_lat:4};
        vecs[2] = '{cl:0, addr:23'h7FFFFF, ack_d:2, rdy_d:3, data:16'hFFFF, exp_sa:23'h7FFFFF, exp_lat:7};
        vecs[3] = '{cl:1, addr:23'h000000, ack_d:0, rdy_d:0, data:16'h1234, exp_sa:23'h000000, exp_lat:2};
        vecs[4] = '{cl:2, addr:23'h03FFFF, ack_d:1, rdy_d:0, data:16'h0001, exp_sa:23'h05FFFF, exp_lat:3};
        vecs[5] = '{cl:2, addr:23'h000010, ack_d:0, rdy_d:1, data:16'hA0A0, exp_sa:23'h020010, exp_lat:3};

        for (int k = 0; k < 3; k++) begin cur_cs[k] = 1'b0; cur_addr[k] = 23'd0; end
        apply();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_req", 32'(sdram_req), 32'd0);
        check("rst_addr", 32'(sdram_addr), 32'd0);
        check("rst_ok", 32'(ok_all), 32'd0);
        for (int k = 0; k < 3; k++) check("rst_data", 32'(data_all[k]), 32'd0);

        for (int i = 0; i < 6; i++) run_single(vecs[i]);

        arb_round(23'h000110);
        arb_round(23'h000330);

        // Address change while the fill is outstanding.
        ack_dly = 0; rdy_dly = 3; force_en = 1'b0;
        @(negedge clk);
        drive_client(1, 1'b1, 23'h000200);
        hit = 1'b0;
        for (int c = 0; c < 10 && !hit; c++) begin @(negedge clk); hit = sdram_req; end
        check("chg_req_up", 32'(hit), 32'd1);
        hit = 1'b0;
        for (int c = 0; c < 10 && !hit; c++) begin @(negedge clk); hit = !sdram_req; end
        check("chg_req_down", 32'(hit), 32'd1);
        drive_client(1, 1'b1, 23'h000201);
        n = 0; bad_ok = 1'b0; prev = sdram_req; a2 = 23'd0;
        for (int c = 0; c < 30 && !(n >= 1 && vobj_ok); c++) begin
            @(negedge clk);
            if (sdram_req && !prev) begin n++; a2 = sdram_addr; end
            if (vobj_ok && n == 0) bad_ok = 1'b1;
            prev = sdram_req;
        end
        check("chg_ok_early", 32'(bad_ok), 32'd0);
        check("chg_req2_addr", 32'(a2), 32'h201);
        check("chg_ok_final", 32'(vobj_ok), 32'd1);
        check("chg_data", 32'(vobj_data), 32'(mem_word(23'h000201)));
        drive_client(1, 1'b0, 23'h000201);
        repeat (3) @(negedge clk);

        // Reset pulsed while waiting for ack.
        ack_dly = 6; rdy_dly = 1;
        @(negedge clk);
        drive_client(0, 1'b1, 23'h000040);
        hit = 1'b0;
        for (int c = 0; c < 10 && !hit; c++) begin @(negedge clk); hit = sdram_req; end
        check("rstw_req_up", 32'(hit), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstw_req", 32'(sdram_req), 32'd0);
        check("rstw_ok", 32'(ok_all), 32'd0);
        check("rstw_addr", 32'(sdram_addr), 32'd0);
        #1 rst = 1'b0;
        drive_client(0, 1'b0, 23'h000040);
        repeat (15) @(negedge clk);
        check("rstw_idle", 32'(sdram_req), 32'd0);
        run_single('{cl:0, addr:23'h000044, ack_d:0, rdy_d:1, data:16'h4444, exp_sa:23'h000044, exp_lat:3});

        // Random traffic against the cached-word contract.
        rand_resp = 1'b1; force_en = 1'b0;
        for (int k = 0; k < 3; k++) wait_cnt[k] = 0;
        repeat (1500) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                hit = 1'b0;
                if ($urandom_range(0, 31) == 0) begin
                    na = 23'(k * 23'h100 + $urandom_range(0, 3));
                    hit = (na != cur_addr[k]);
                    cur_addr[k] = na;
                end
                if ($urandom_range(0, 31) == 0) begin cur_cs[k] = ~cur_cs[k]; hit = 1'b1; end
                if (hit || !cur_cs[k]) wait_cnt[k] = 0;
            end
            apply();
            #1;
            for (int k = 0; k < 3; k++) begin
                if (ok_all[k])
                    check("rnd_data", 32'(data_all[k]), 32'(mem_word(eff_addr(k, cur_addr[k]))));
                if (!cur_cs[k]) check("rnd_ok_cs", 32'(ok_all[k]), 32'd0);
                if (cur_cs[k] && !ok_all[k]) wait_cnt[k]++;
                else                         wait_cnt[k] = 0;
                check("rnd_live", 32'(wait_cnt[k] > 200), 32'd0);
            end
        end
        for (int k = 0; k < 3; k++) cur_cs[k] = 1'b0;
        apply();
        repeat (10) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
